// File: rtl/seven_segment_reader.sv
// -----------------------------------------------------------------------------
// seven_segment_reader
//
// Recovers a two-digit decimal number from a multiplexed seven-segment display
// that is driven asynchronously to clk. The {digit,segments} lines are
// synchronized and must be stable for STABLE_CYCLES cycles before one sample
// is taken. A units sample and a tens sample, in either order, make a complete
// reading. The reading is then published on tens/units/value with a one-cycle
// valid pulse.
//
// Optional feature macro: SEG_READER_ERR_EN
//   When defined, the err port exists. A stable pattern that cannot be decoded
//   pulses err and drops any held digit. When undefined, such patterns are
//   ignored and the held digit is kept.
//
// Parameters
//   STABLE_CYCLES  cycles of unchanged synchronized input before a sample is
//                  taken (2..255)
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   reset     in   synchronous, active-high reset
//   segments  in   [6:0] segment lines, active-high, bit0=a .. bit6=g (async)
//   digit     in   digit select, 0 = units shown, 1 = tens shown (async)
//   tens      out  [3:0] last published tens digit (BCD)
//   units     out  [3:0] last published units digit (BCD)
//   value     out  [6:0] tens*10+units
//   valid     out  one-cycle pulse when tens/units/value are updated
//   err       out  one-cycle pulse on a stable undecodable pattern (macro only)
// -----------------------------------------------------------------------------
module seven_segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic       digit,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] value,
`ifdef SEG_READER_ERR_EN
    output logic       valid,
    output logic       err
`else
    output logic       valid
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_U = 2'd1,
        HAVE_T = 2'd2
    } state_e;

    // Returns {ok, bcd}. ok is low for every pattern outside the ten digits.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode_seg = {1'b1, 4'd0};
            7'h06:   decode_seg = {1'b1, 4'd1};
            7'h5B:   decode_seg = {1'b1, 4'd2};
            7'h4F:   decode_seg = {1'b1, 4'd3};
            7'h66:   decode_seg = {1'b1, 4'd4};
            7'h6D:   decode_seg = {1'b1, 4'd5};
            7'h7D:   decode_seg = {1'b1, 4'd6};
            7'h07:   decode_seg = {1'b1, 4'd7};
            7'h7F:   decode_seg = {1'b1, 4'd8};
            7'h6F:   decode_seg = {1'b1, 4'd9};
            default: decode_seg = {1'b0, 4'd0};
        endcase
    endfunction

    // Widen before the multiply so 9*10+9 = 99 fits without truncation.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] t,
                                              input logic [3:0] u);
        bcd_to_bin = ({3'b000, t} * 7'd10) + {3'b000, u};
    endfunction

    // ---------------------------------------------------------------------
    // Two-flop synchronizer plus one previous-cycle copy for change detect.
    // Bit 7 is digit, bits 6:0 are segments.
    // ---------------------------------------------------------------------
    logic [7:0] meta_q;
    logic [7:0] sync_q;
    logic [7:0] prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the value from before the edge, which keeps the chain a true
    // shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= {digit, segments};
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    logic changed;
    assign changed = (sync_q != prev_q);

    // ---------------------------------------------------------------------
    // Stability counter. It saturates at STABLE_CYCLES, so it passes
    // STABLE_CYCLES-1 only once per stable period. That gives one sample.
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: cnt_d gets a default before any branch. Without it, a path that
    // does not assign it would infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    logic       sample;
    logic       sample_digit;
    logic       seg_ok;
    logic [3:0] seg_bcd;

    assign sample            = !changed && (cnt_q == CNT_FIRE);
    assign sample_digit      = sync_q[7];
    assign {seg_ok, seg_bcd} = decode_seg(sync_q[6:0]);

    // ---------------------------------------------------------------------
    // Assembly FSM with registered outputs.
    // ---------------------------------------------------------------------
    state_e     state_q;
    logic [3:0] held_u_q;
    logic [3:0] held_t_q;
    logic [3:0] tens_q;
    logic [3:0] units_q;
    logic [6:0] value_q;
    logic       valid_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the held digits are cleared here as well as the state.
            // A reset in the middle of a capture then cannot complete a
            // stale pair later.
            state_q  <= IDLE;
            held_u_q <= '0;
            held_t_q <= '0;
            tens_q   <= '0;
            units_q  <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (sample && seg_ok) begin
                case (state_q)
                    IDLE: begin
                        if (sample_digit) begin
                            held_t_q <= seg_bcd;
                            state_q  <= HAVE_T;
                        end else begin
                            held_u_q <= seg_bcd;
                            state_q  <= HAVE_U;
                        end
                    end
                    HAVE_U: begin
                        if (sample_digit) begin
                            tens_q  <= seg_bcd;
                            units_q <= held_u_q;
                            value_q <= bcd_to_bin(seg_bcd, held_u_q);
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            held_u_q <= seg_bcd;
                        end
                    end
                    HAVE_T: begin
                        if (!sample_digit) begin
                            tens_q  <= held_t_q;
                            units_q <= seg_bcd;
                            value_q <= bcd_to_bin(held_t_q, seg_bcd);
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            held_t_q <= seg_bcd;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
`ifdef SEG_READER_ERR_EN
            end else if (sample && !seg_ok) begin
                // A garbage stable pattern drops any partial reading.
                err_q   <= 1'b1;
                state_q <= IDLE;
`endif
            end
        end
    end

    assign tens  = tens_q;
    assign units = units_q;
    assign value = value_q;
    assign valid = valid_q;

`ifdef SEG_READER_ERR_EN
    assign err = err_q;
`else
    // Without the error option err_q is never set and is left unconnected.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_reader
//
// Directed, self-checking bench for seven_segment_reader with
// STABLE_CYCLES = 4. Each expected reading is pushed to a scoreboard queue
// when the completing digit is driven. A monitor pops and compares an entry
// on every valid pulse. It also flags any pulse that arrives with nothing
// expected.
// -----------------------------------------------------------------------------
module tb_seven_segment_reader;

    localparam int unsigned STABLE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] segments;
    logic       digit;
    logic [3:0] tens;
    logic [3:0] units;
    logic [6:0] value;
    logic       valid;
`ifdef SEG_READER_ERR_EN
    logic       err;
`endif

    seven_segment_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk      (clk),
        .reset    (reset),
        .segments (segments),
        .digit    (digit),
        .tens     (tens),
        .units    (units),
        .value    (value),
`ifdef SEG_READER_ERR_EN
        .valid    (valid),
        .err      (err)
`else
        .valid    (valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] u;
        logic [6:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   checks     = 0;
    int   failures   = 0;
    int   valid_cnt  = 0;
    int   err_cnt    = 0;
    int   base_valid = 0;
    int   base_err   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt++;
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_cur = exp_q.pop_front();
                check("sb_tens",  32'(tens),  32'(exp_cur.t));
                check("sb_units", 32'(units), 32'(exp_cur.u));
                check("sb_value", 32'(value), 32'(exp_cur.v));
            end
        end
`ifdef SEG_READER_ERR_EN
        if (err === 1'b1) err_cnt++;
`endif
    end

    // Drive one {digit,segments} pattern and hold it for n cycles.
    // The inputs change 1 ns after the edge.
    task automatic hold(input logic d, input logic [6:0] s, input int n);
        digit    = d;
        segments = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input int t, input int u);
        exp_q.push_back('{t: 4'(t), u: 4'(u), v: 7'(t * 10 + u)});
    endtask

    // Bounded wait for the scoreboard to empty.
    // An expired bound counts as a failed check.
    task automatic wait_drain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        digit    = 1'b0;
        segments = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tens",  32'(tens),  32'd0);
        check("rst_units", 32'(units), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
`ifdef SEG_READER_ERR_EN
        check("rst_err",   32'(err),   32'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // The input toggles every 2 cycles, too fast to ever be sampled.
        base_valid = valid_cnt;
        for (int i = 0; i < 50; i++) begin
            if (i % 2 == 0) hold(1'b0, 7'h3F, 2);
            else            hold(1'b1, 7'h06, 2);
        end
        check("toggle_no_valid", 32'(valid_cnt - base_valid), 32'd0);
        check("toggle_value",    32'(value), 32'd0);

        // Units 3 (4F), then tens 5 (6D), gives 53.
        base_valid = valid_cnt;
        hold(1'b0, 7'h4F, 10);
        expect_read(5, 3);
        hold(1'b1, 7'h6D, 10);
        wait_drain("drain_53", 20);
        check("pulses_53", 32'(valid_cnt - base_valid), 32'd1);
        check("hold_value_53", 32'(value), 32'd53);

        // Units 1 is overwritten by units 8, then tens 9 gives 98.
        base_valid = valid_cnt;
        hold(1'b0, 7'h06, 8);
        hold(1'b0, 7'h7F, 8);
        expect_read(9, 8);
        hold(1'b1, 7'h6F, 8);
        wait_drain("drain_98", 20);
        check("pulses_98", 32'(valid_cnt - base_valid), 32'd1);

        // Boundary values: 00, then 99.
        base_valid = valid_cnt;
        hold(1'b0, 7'h3F, 8);
        expect_read(0, 0);
        hold(1'b1, 7'h3F, 8);
        hold(1'b0, 7'h6F, 8);
        expect_read(9, 9);
        hold(1'b1, 7'h6F, 8);
        wait_drain("drain_00_99", 20);
        check("pulses_00_99", 32'(valid_cnt - base_valid), 32'd2);

        // Capture units 7, then reset. The held 7 must be discarded.
        hold(1'b0, 7'h07, 8);
        reset    = 1'b1;
        digit    = 1'b1;
        segments = 7'h06;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_value", 32'(value), 32'd0);
        base_valid = valid_cnt;
        hold(1'b1, 7'h06, 10);
        check("midrst_no_valid", 32'(valid_cnt - base_valid), 32'd0);
        expect_read(1, 2);
        hold(1'b0, 7'h5B, 10);
        wait_drain("drain_12", 20);
        check("pulses_12", 32'(valid_cnt - base_valid), 32'd1);

        // A blank (00) tens pattern arrives while units 4 is held.
        base_valid = valid_cnt;
        base_err   = err_cnt;
        hold(1'b0, 7'h66, 8);
        hold(1'b1, 7'h00, 10);
        check("blank_no_valid", 32'(valid_cnt - base_valid), 32'd0);
`ifdef SEG_READER_ERR_EN
        check("blank_err_pulse", 32'(err_cnt - base_err), 32'd1);
        // The held units were dropped, so the tens goes in first.
        hold(1'b1, 7'h06, 8);
        expect_read(1, 4);
        hold(1'b0, 7'h66, 8);
`else
        // The blank was ignored and units 4 is still held.
        expect_read(1, 4);
        hold(1'b1, 7'h06, 8);
        hold(1'b0, 7'h66, 8);
`endif
        wait_drain("drain_14", 20);
        check("pulses_14", 32'(valid_cnt - base_valid), 32'd1);
        check("final_value", 32'(value), 32'd14);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning number of consecutive cycles the synchronized {digit,segments} must be unchanged before a sample is taken; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 segments  input  7  multiplexed seven-segment lines, active-high, bit0=a ... bit6=g; asynchronous to clk.
REQ-005 digit  input  1  digit select; 0 = units digit displayed, 1 = tens digit displayed; asynchronous to clk.
REQ-006 tens  output  4  last captured tens digit, BCD.
REQ-007 units  output  4  last captured units digit, BCD.
REQ-008 value  output  7  binary value tens*10+units, range 0..99.
REQ-009 valid  output  1  one-cycle pulse; tens/units/value updated this cycle.
REQ-010 err  output  1  one-cycle pulse on a stable, undecodable pattern (present only with SEG_READER_ERR_EN).

Function
REQ-011 segments and digit SHALL each pass through a two-flop synchronizer; all further logic uses synchronized copies.
REQ-012 Stability counter SHALL clear whenever synchronized {digit,segments} differs from its previous-cycle value, else increment, saturating at STABLE_CYCLES.
REQ-013 Exactly one sample SHALL be taken per stable period, on the cycle the counter reaches STABLE_CYCLES-1; no further samples until the next change.
REQ-014 Decode table (hex, bit0=a): 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9; every other pattern, including 00, is invalid.
REQ-015 FSM states: IDLE (nothing held), HAVE_U (units held), HAVE_T (tens held).
REQ-016 IDLE: valid sample with digit=0 -> HAVE_U; digit=1 -> HAVE_T.
REQ-017 HAVE_U: valid tens sample -> emit, IDLE; valid units sample -> overwrite held units, stay.
REQ-018 HAVE_T: valid units sample -> emit, IDLE; valid tens sample -> overwrite held tens, stay.
REQ-019 Emit: tens, units, value SHALL register and valid SHALL pulse high on the cycle after the completing sample; outputs hold until next emit.
REQ-020 value SHALL be computed as tens*10+units in at least 7 bits with no truncation of legal inputs.
REQ-021 Latency from input change to valid SHALL be 2 (sync) + STABLE_CYCLES + 1 cycles for the completing digit.
REQ-022 Invalid samples SHALL NOT update held digits or outputs.

Reset
REQ-023 While reset is high: synchronizers, stability counter, held digits cleared; FSM = IDLE; tens=0, units=0, value=0, valid=0, err=0.
REQ-024 Reset asserted mid-capture SHALL discard any held digit; no valid pulse for it after reset release.
REQ-025 First sample after reset release requires a full stable period measured from release.

Configuration
REQ-026 Macro SEG_READER_ERR_EN defined: err port exists; invalid stable sample pulses err one cycle after the sample and forces FSM to IDLE.
REQ-027 SEG_READER_ERR_EN undefined: err port and logic absent; invalid samples ignored, FSM state unchanged.

Verification
REQ-028 After reset, digit=0 segments=4F stable 10 cycles, then digit=1 segments=6D stable 10 cycles -> one valid pulse, tens=5, units=3, value=53.
REQ-029 {digit,segments} toggled every 2 cycles with STABLE_CYCLES=4 for 100 cycles -> no valid, outputs remain 0.
REQ-030 Units 06, then units 7F, then tens 6F, each stable 8 cycles -> single valid, value=98 (units overwritten).
REQ-031 Units 3F, tens 3F -> value=0 valid; then units 6F, tens 6F -> value=99 valid; exactly two pulses.
REQ-032 Units 07 captured, reset pulsed 1 cycle, tens 06 stable -> no valid; then units 5B -> valid, value=12.
REQ-033 With SEG_READER_ERR_EN: units 66 captured, tens segments=00 stable -> err pulse, no valid; tens 06, units 66 -> value=14 valid; without macro the 00 is ignored and value=14 follows the tens 06.
